// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide unit (radix-2, fixed 34-cycle latency)
// Revision 1.0
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int         CW     = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  logic [1:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  // Request decode and operand conditioning
  logic             valid_code, accept, in_div, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign valid_code = (alucontrol[4:3] == 2'b10);
  assign accept     = (state_q == S_IDLE) && start && valid_code && !flush;
  assign in_div     = alucontrol[2];
  assign a_signed   = in_div ? !alucontrol[0]
                             : (alucontrol[1:0] == 2'b01) || (alucontrol[1:0] == 2'b10);
  assign b_signed   = in_div ? !alucontrol[0] : (alucontrol[1:0] == 2'b01);
  assign a_neg      = a_signed && operand_a[WIDTH-1];
  assign b_neg      = b_signed && operand_b[WIDTH-1];
  assign a_mag      = a_neg ? -operand_a : operand_a;
  assign b_mag      = b_neg ? -operand_b : operand_b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; trial is 33 bits so a
  // shifted remainder up to 2*divisor-1 never overflows.
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_step;
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign div_step  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = dz_q ? {WIDTH{1'b1}}
                         : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_res = quo_fix;
    case (op_q)
      3'b000:                fix_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:        fix_res = quo_fix;
      default:               fix_res = rem_fix;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_CALC;
        S_CALC:  if (cnt_q == CNT_LAST) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_CALC) || (state_q == S_FIX);
  end

  assign done   = done_q;
  assign result = result_q;

  // Datapath next-state
  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d   = alucontrol[2:0];
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            dz_d   = (operand_b == '0);
            cnt_d  = '0;
            opnd_d = in_div ? b_mag : a_mag;
            acc_d  = {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
          end
        end
        S_CALC: begin
          acc_d = op_q[2] ? div_step : mul_step;
          cnt_d = cnt_q + 1'b1;
        end
        S_FIX: begin
          result_d = fix_res;
          done_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : randomized self-checking bench against an arithmetic model
// Revision 1.0
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  alucontrol;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_exp = '0;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alucontrol (alucontrol),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] code,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic signed [31:0] sa, sb, sr;
    sa = a;
    sb = b;
    ea = {32'b0, a};
    eb = {32'b0, b};
    case (code)
      5'b10000: begin p = ea * eb; return p[31:0]; end
      5'b10001: begin
        ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; p = ea * eb; return p[63:32];
      end
      5'b10010: begin ea = {{32{a[31]}}, a}; p = ea * eb; return p[63:32]; end
      5'b10011: begin p = ea * eb; return p[63:32]; end
      5'b10100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        sr = sa / sb; return sr;
      end
      5'b10101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      5'b10110: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        sr = sa % sb; return sr;
      end
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return $urandom_range(0, 20);
      5:       return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Entered on a falling edge; leaves on the falling edge where done is seen,
  // so consecutive calls exercise back-to-back acceptance.
  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input bit poke_busy);
    logic [31:0] exp;
    bit got_done;
    int lat, busy_cnt;
    exp        = ref_model(code, a, b);
    start      = 1'b1;
    alucontrol = code;
    operand_a  = a;
    operand_b  = b;
    got_done   = 0;
    lat        = 0;
    busy_cnt   = 0;
    for (int k = 1; k <= 40 && !got_done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start     = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        alucontrol = 5'(16 + $urandom_range(0, 7));
        chk("done_one_cycle", {31'b0, done}, 32'd0);
      end
      if (poke_busy && k == 5) start = 1'b1;
      if (poke_busy && k == 6) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1;
        lat      = k;
      end
    end
    chk("latency", lat, 34);
    chk("busy_cycles", busy_cnt, 33);
    chk($sformatf("result code=%b a=%h b=%h", code, a, b), result, exp);
    last_exp = exp;
  endtask

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[] = '{
    '{5'b10000, 32'd7,        32'd6},
    '{5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{5'b10010, 32'hFFFFFFFF, 32'd2},
    '{5'b10100, -32'd7,       32'd2},
    '{5'b10110, -32'd7,       32'd2},
    '{5'b10101, 32'd100,      32'd7},
    '{5'b10111, 32'd100,      32'd7},
    '{5'b10100, 32'd5,        32'd0},
    '{5'b10110, 32'd5,        32'd0},
    '{5'b10100, 32'h80000000, 32'hFFFFFFFF},
    '{5'b10110, 32'h80000000, 32'hFFFFFFFF}
  };

  initial begin
    int dcount;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    alucontrol = '0; operand_a = '0; operand_b = '0;
    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (dir[i]) run_op(dir[i].code, dir[i].a, dir[i].b, (i % 3) == 1);

    // Flush a divide in flight
    start = 1'b1; alucontrol = 5'b10100; operand_a = 32'd1000; operand_b = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("flush_no_done", dcount, 0);
    chk("flush_result_kept", result, last_exp);

    // Unsupported code is ignored
    start = 1'b1; alucontrol = 5'b00010; operand_a = 32'd3; operand_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("bad_code_busy", {31'b0, busy}, 32'd0);

    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1; alucontrol = 5'b10000;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);

    // Reset in the middle of a multiply
    start = 1'b1; alucontrol = 5'b10000; operand_a = 32'd9; operand_b = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_done", {31'b0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 150; i++)
      run_op(5'(16 + $urandom_range(0, 7)), pick_operand(), pick_operand(), (i % 5) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the ALU control decoder, beside the single-cycle ALU in the execute stage.
- Consumes the 5-bit ALU control code plus both operands, runs a radix-2 shift/add or shift/subtract sequence, and returns a 32-bit result with a busy/done handshake so the pipeline can stall.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.
- ITER, 32, iteration count (equals WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- alucontrol  input  5  operation code from ALU control
- operand_a  input  32  rs1 value (multiplicand/dividend)
- operand_b  input  32  rs2 value (multiplier/divisor)
- flush  input  1  pipeline kill; aborts any operation
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse, result valid
- result  output  32  product half, quotient or remainder

Behaviour:
- Codes:
  - 5'b10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - Any other code with start is ignored; the unit stays in IDLE.
- Reset, asynchronous on rst_n low:
  - state=IDLE, busy=0, done=0, result=0.
  - All internal registers cleared.
  - Reset mid-operation discards the operation with no done.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start with a valid code, at edge E0: latch code, operand magnitudes and result-sign flags; clear iteration counter; go to CALC; busy=1 from E0.
  - Signedness: MULH, DIV and REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. All other codes are unsigned.
- CALC:
  - One iteration per cycle, edges E1..E32; counter 0..31.
  - Multiply: 64-bit accumulator, shift-add on magnitudes.
  - Divide: restoring shift-subtract on magnitudes, giving 32-bit quotient and remainder.
  - When counter==31, go to FIX.
- FIX, edge E33:
  - Apply sign correction.
    - Product: negate if the sign flags differ.
    - Quotient: negate if signs differ.
    - Remainder: takes the dividend's sign.
  - Register result:
    - MUL: low 32 bits of the product.
    - MULH, MULHSU, MULHU: high 32 bits.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Set done=1, busy=0; return to IDLE.
  - done deasserts after one cycle.
- Fixed latency: done is high in the cycle after E33, i.e. 34 cycles from start acceptance. No early-out.
- Divide by zero (operand_b==0), any divide code:
  - quotient = 32'hFFFFFFFF.
  - remainder = operand_a.
  - Same latency as a normal divide.
- Signed overflow, DIV/REM with 32'h80000000 / 32'hFFFFFFFF:
  - quotient = 32'h80000000, remainder = 0.
- start while busy is ignored. Operands are latched at E0; later input changes have no effect.
- flush:
  - Synchronous. On any edge with flush=1: state goes to IDLE, busy=0, done=0. result is unchanged.
  - flush and start together in IDLE: flush wins; the operation is not accepted.
- result holds its value until the next completed operation. It is not cleared at a new start.
- A new start may be accepted in the same cycle that done is high, since the state is already IDLE.

Test Plan:
- MUL 7 x 6 -> done after 34 cycles, result=32'd42, busy high for exactly 33 cycles.
- MULH 32'hFFFFFFFF x 32'hFFFFFFFF -> result=0. MULHU with the same operands -> result=32'hFFFFFFFE. MULHSU 32'hFFFFFFFF x 2 -> result=32'hFFFFFFFF.
- DIV -7 / 2 -> 32'hFFFFFFFD. REM -7 / 2 -> 32'hFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 32'hFFFFFFFF. REM 5 / 0 -> 5. DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000. REM with the same operands -> 0.
- flush at cycle 10 of a DIV -> busy drops next edge, no done pulse, result keeps its prior value. start with code 5'b00010 -> no busy.
- rst_n low mid-MUL -> busy, done and result clear immediately. Back-to-back start on the done cycle is accepted and completes correctly. start while busy is ignored.
